// File: rtl/conv_window_scanner.sv
// conv_window_scanner
//
// Sliding-window generator for the CNN feature-extraction path. On start it
// captures the flattened padded matrix N_P and then emits every K x K window
// in row-major scan order, one window per accepted valid/ready handshake.
// Each window carries its top-left coordinate.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   clr        synchronous clear, active high; abandons any scan
//   start      begin a scan (only looked at while idle)
//   N_P        padded matrix, element (r,c) at [(r*C_N_P+c)*In_d_W +: In_d_W]
//   win_valid  window on win is valid
//   win_ready  consumer accepts the current window
//   win        window, element (i,j) at [(i*K+j)*In_d_W +: In_d_W]
//   win_row    top-left row of the current window
//   win_col    top-left column of the current window
//   busy       high whenever a scan is in progress (state not IDLE)
//   done       one-cycle pulse after the last window has been accepted
module conv_window_scanner #(
    parameter int In_d_W = 32,
    parameter int R_N_P  = 5,
    parameter int C_N_P  = 5,
    parameter int K      = 3,
    parameter int S      = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             start,
    input  logic [R_N_P*C_N_P*In_d_W-1:0]    N_P,
    output logic                             win_valid,
    input  logic                             win_ready,
    output logic [K*K*In_d_W-1:0]            win,
    output logic [$clog2(R_N_P)-1:0]         win_row,
    output logic [$clog2(C_N_P)-1:0]         win_col,
    output logic                             busy,
    output logic                             done
);

    localparam int MW       = R_N_P * C_N_P * In_d_W;
    localparam int WW       = K * K * In_d_W;
    localparam int RW       = $clog2(R_N_P);
    localparam int CW       = $clog2(C_N_P);
    localparam int NR       = (R_N_P - K) / S + 1;
    localparam int NC       = (C_N_P - K) / S + 1;
    localparam int LAST_ROW = (NR - 1) * S;
    localparam int LAST_COL = (NC - 1) * S;
    localparam int MIW      = $clog2(MW);
    localparam int WIW      = $clog2(WW);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [MW-1:0]   mat_q;
    logic            accept;
    logic            last_win;
    logic [RW-1:0]   row_nxt;
    logic [CW-1:0]   col_nxt;

    // Copy the K x K block whose top-left corner is (r,c) out of a flattened
    // matrix. Pure wiring, no arithmetic on the data.
    function automatic logic [WW-1:0] extract_window(input logic [MW-1:0] m,
                                                      input int r,
                                                      input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w[WIW'((i*K + j) * In_d_W) +: In_d_W] =
                    m[MIW'(((r + i) * C_N_P + (c + j)) * In_d_W) +: In_d_W];
            end
        end
        return w;
    endfunction

    assign accept   = (state_q == SCAN) && win_ready;
    assign last_win = (int'(win_row) == LAST_ROW) && (int'(win_col) == LAST_COL);

    // Next scan position: step right by the stride while another window still
    // fits in the row, otherwise wrap to column 0 of the next window row.
    always_comb begin
        row_nxt = win_row;
        col_nxt = win_col;
        if (int'(win_col) + S <= C_N_P - K) begin
            col_nxt = CW'(int'(win_col) + S);
        end else begin
            col_nxt = '0;
            row_nxt = RW'(int'(win_row) + S);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr beats everything so a scan is dropped silently.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SCAN;
                SCAN:    if (accept && last_win) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Status outputs decode straight from the state so reset clears them at once.
    always_comb begin
        win_valid = (state_q == SCAN);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

    // Datapath: capture the matrix at start, then reload the window from the
    // captured copy on every accepted handshake. Without an accept everything
    // holds, which gives the stable-under-backpressure behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mat_q   <= '0;
            win     <= '0;
            win_row <= '0;
            win_col <= '0;
        end else if (clr) begin
            mat_q   <= '0;
            win     <= '0;
            win_row <= '0;
            win_col <= '0;
        end else if ((state_q == IDLE) && start) begin
            mat_q   <= N_P;
            win     <= extract_window(N_P, 0, 0);
            win_row <= '0;
            win_col <= '0;
        end else if (accept && !last_win) begin
            win     <= extract_window(mat_q, int'(row_nxt), int'(col_nxt));
            win_row <= row_nxt;
            win_col <= col_nxt;
        end
    end

endmodule

// File: tb/tb_conv_window_scanner.sv
// tb_conv_window_scanner
//
// Bench for conv_window_scanner. Drives a default instance (stride 1) and a
// stride-2 instance from a 5x5 matrix whose element (r,c) is 10r+c. Expected
// windows are queued when a scan starts and popped as the DUT hands them off.
module tb_conv_window_scanner;

    localparam int W  = 32;
    localparam int R  = 5;
    localparam int C  = 5;
    localparam int KW = 3;
    localparam int WW = KW * KW * W;
    localparam int MW = R * C * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic          win_ready = 1'b0;
    logic          win_ready2 = 1'b0;
    logic [MW-1:0] n_p;

    logic          win_valid, busy, done;
    logic [WW-1:0] win;
    logic [2:0]    win_row, win_col;
    logic          win_valid2, busy2, done2;
    logic [WW-1:0] win2;
    logic [2:0]    win_row2, win_col2;

    logic [31:0]   mdl [R][C];
    int            checks = 0;
    int            errors = 0;
    int            win_seen = 0;

    typedef struct {
        logic [2:0]    row;
        logic [2:0]    col;
        logic [WW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic       start;
        logic       ready;
        logic       push;
        logic       exp_valid;
        logic       exp_busy;
        logic       exp_done;
        logic [2:0] exp_row;
        logic [2:0] exp_col;
    } vec_t;

    vec_t tbl[32];
    int   nvec = 0;

    always #5 clk = ~clk;

    conv_window_scanner #(.In_d_W(W), .R_N_P(R), .C_N_P(C), .K(KW), .S(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .N_P(n_p),
        .win_valid(win_valid), .win_ready(win_ready), .win(win),
        .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
    );

    conv_window_scanner #(.In_d_W(W), .R_N_P(R), .C_N_P(C), .K(KW), .S(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .start(start2), .N_P(n_p),
        .win_valid(win_valid2), .win_ready(win_ready2), .win(win2),
        .win_row(win_row2), .win_col(win_col2), .busy(busy2), .done(done2)
    );

    // Reference window built from the 2-D model matrix.
    function automatic logic [WW-1:0] modelWin(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < KW; i++)
            for (int j = 0; j < KW; j++)
                w[(i*KW + j)*W +: W] = mdl[r + i][c + j];
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                               input logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkLiteral(input string name, input logic [WW-1:0] actual,
                                input int vals[9]);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*W +: W] = vals[k];
        checkOutput(name, actual, w);
    endtask

    task automatic applyStimulus(input logic s, input logic rdy, input logic c);
        start     = s;
        win_ready = rdy;
        clr       = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveNp(input logic all_ones);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                n_p[(r*C + c)*W +: W] = all_ones ? 32'hFFFF_FFFF : 32'(10*r + c);
    endtask

    task automatic pushScan();
        exp_t e;
        for (int r = 0; r <= R - KW; r++)
            for (int c = 0; c <= C - KW; c++) begin
                e.row  = 3'(r);
                e.col  = 3'(c);
                e.data = modelWin(r, c);
                exp_q.push_back(e);
            end
    endtask

    task automatic addVec(input logic s, input logic rdy, input logic push,
                          input logic v, input logic b, input logic d,
                          input int r, input int c);
        tbl[nvec].start     = s;
        tbl[nvec].ready     = rdy;
        tbl[nvec].push      = push;
        tbl[nvec].exp_valid = v;
        tbl[nvec].exp_busy  = b;
        tbl[nvec].exp_done  = d;
        tbl[nvec].exp_row   = 3'(r);
        tbl[nvec].exp_col   = 3'(c);
        nvec++;
    endtask

    task automatic runTable(input int first, input int last);
        int lit[9];
        lit = '{12, 13, 14, 22, 23, 24, 32, 33, 34};
        for (int i = first; i <= last; i++) begin
            applyStimulus(tbl[i].start, tbl[i].ready, 1'b0);
            if (tbl[i].push) pushScan();
            tick();
            checkOutput($sformatf("vec%0d valid", i), win_valid, tbl[i].exp_valid);
            checkOutput($sformatf("vec%0d busy", i), busy, tbl[i].exp_busy);
            checkOutput($sformatf("vec%0d done", i), done, tbl[i].exp_done);
            if (tbl[i].exp_valid) begin
                checkOutput($sformatf("vec%0d pos", i), {win_row, win_col},
                            {tbl[i].exp_row, tbl[i].exp_col});
                checkOutput($sformatf("vec%0d win", i), win,
                            modelWin(int'(tbl[i].exp_row), int'(tbl[i].exp_col)));
            end
            if (i == 5) checkLiteral("window (1,2) literal", win, lit);
        end
        checkOutput("table scoreboard empty", exp_q.size() == 0, 1);
    endtask

    // Run a scan out to IDLE with a bounded cycle budget.
    task automatic runToIdle(input string tag, input int exp_windows);
        int dc;
        bit finished;
        dc = 0;
        finished = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done) dc++;
            if (!busy) begin
                finished = 1;
                break;
            end
        end
        checkOutput({tag, " reached idle"}, finished, 1);
        checkOutput({tag, " done pulses"}, dc, 1);
        checkOutput({tag, " windows"}, win_seen, exp_windows);
        checkOutput({tag, " scoreboard empty"}, exp_q.size() == 0, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid"}, win_valid, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " win"}, win, 0);
        checkOutput({tag, " pos"}, {win_row, win_col}, 0);
    endtask

    // Scoreboard consumer: a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (rst && win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb unexpected window: got (%0d,%0d) expected none",
                         win_row, win_col);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb pos", {win_row, win_col}, {e.row, e.col});
                checkOutput("sb win", win, e.data);
                win_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lit2[9];
        int pos2[4][2];

        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mdl[r][c] = 32'(10*r + c);
        driveNp(1'b0);

        // Reset state
        #2 rst = 1'b0;
        #10;
        checkAllZero("reset");
        checkOutput("reset valid2", win_valid2, 0);
        rst = 1'b1;

        // Full scan, ready high: vectors 0..10
        addVec(1, 1, 1, 1, 1, 0, 0, 0);
        for (int k = 1; k < 9; k++) addVec(0, 1, 0, 1, 1, 0, k / 3, k % 3);
        addVec(0, 1, 0, 0, 1, 1, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 0, 0);
        // Backpressure on window (0,1) for four cycles: vectors 11..25
        addVec(1, 1, 1, 1, 1, 0, 0, 0);
        addVec(0, 1, 0, 1, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) addVec(0, 0, 0, 1, 1, 0, 0, 1);
        for (int k = 2; k < 9; k++) addVec(0, 1, 0, 1, 1, 0, k / 3, k % 3);
        addVec(0, 1, 0, 0, 1, 1, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] full scan");
        win_seen = 0;
        runTable(0, 10);
        checkOutput("full scan windows", win_seen, 9);
        $display("[TB] backpressure scan");
        win_seen = 0;
        runTable(11, nvec - 1);
        checkOutput("backpressure windows", win_seen, 9);

        // start and N_P changes mid-scan
        $display("[TB] mid-scan start / N_P change");
        win_seen = 0;
        applyStimulus(1, 1, 0);
        pushScan();
        tick();
        applyStimulus(0, 1, 0);
        tick();
        tick();
        applyStimulus(1, 1, 0);
        driveNp(1'b1);
        tick();
        applyStimulus(0, 1, 0);
        checkOutput("midscan pos", {win_row, win_col}, {3'd1, 3'd0});
        checkOutput("midscan win", win, modelWin(1, 0));
        runToIdle("midscan", 9);
        driveNp(1'b0);

        // clr at window 5
        $display("[TB] clear mid-scan");
        applyStimulus(1, 1, 0);
        pushScan();
        tick();
        applyStimulus(0, 1, 0);
        repeat (4) tick();
        checkOutput("pre-clr pos", {win_row, win_col}, {3'd1, 3'd1});
        applyStimulus(0, 1, 1);
        tick();
        checkAllZero("after clr");
        exp_q.delete();
        applyStimulus(0, 1, 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput($sformatf("post-clr done %0d", n), done, 0);
            checkOutput($sformatf("post-clr busy %0d", n), busy, 0);
        end
        win_seen = 0;
        applyStimulus(1, 1, 0);
        pushScan();
        tick();
        applyStimulus(0, 1, 0);
        runToIdle("after clr rescan", 9);

        // Asynchronous reset during window 4
        $display("[TB] async reset mid-scan");
        applyStimulus(1, 1, 0);
        pushScan();
        tick();
        applyStimulus(0, 1, 0);
        repeat (3) tick();
        checkOutput("pre-reset pos", {win_row, win_col}, {3'd1, 3'd0});
        #3 rst = 1'b0;
        #1;
        checkAllZero("async reset");
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checkOutput($sformatf("post-reset busy %0d", n), busy, 0);
            checkOutput($sformatf("post-reset valid %0d", n), win_valid, 0);
        end

        // Stride-2 instance
        $display("[TB] stride 2 scan");
        lit2 = '{22, 23, 24, 32, 33, 34, 42, 43, 44};
        pos2 = '{'{0, 0}, '{0, 2}, '{2, 0}, '{2, 2}};
        start2 = 1'b1;
        win_ready2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("s2 w%0d valid", k), win_valid2, 1);
            checkOutput($sformatf("s2 w%0d pos", k), {win_row2, win_col2},
                        {3'(pos2[k][0]), 3'(pos2[k][1])});
            checkOutput($sformatf("s2 w%0d win", k), win2, modelWin(pos2[k][0], pos2[k][1]));
            if (k == 3) checkLiteral("s2 window (2,2) literal", win2, lit2);
            tick();
        end
        checkOutput("s2 done", done2, 1);
        checkOutput("s2 valid in done", win_valid2, 0);
        tick();
        checkOutput("s2 busy fall", busy2, 0);
        checkOutput("s2 done fall", done2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_scanner.md
# conv_window_scanner

Sliding-window generator sitting directly downstream of `zero_padding` in the CNN feature-extraction path. On `start` it captures the flattened padded matrix `N_P` and emits every K×K convolution window in row-major scan order, one window per accepted handshake. Each window carries its top-left coordinate. Its output feeds the MAC/convolution stage through a valid/ready handshake.

## Interface
- `In_d_W`, 32: element width in bits.
- `R_N_P`, 5: rows of padded input matrix.
- `C_N_P`, 5: columns of padded input matrix.
- `K`, 3: square kernel/window size; must satisfy K ≤ R_N_P and K ≤ C_N_P.
- `S`, 1: stride, ≥1.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear, active-high.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `N_P`  in  R_N_P*C_N_P*In_d_W  padded matrix; element (r,c) at `[(r*C_N_P+c)*In_d_W +: In_d_W]`, so (0,0) is at the LSBs.
- `win_valid`  out  1  window on `win` is valid.
- `win_ready`  in  1  consumer accepts window.
- `win`  out  K*K*In_d_W  window; element (i,j) at `[(i*K+j)*In_d_W +: In_d_W]`.
- `win_row`  out  clog2(R_N_P)  top-left row of current window.
- `win_col`  out  clog2(C_N_P)  top-left column of current window.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last window is accepted.

## Operation
- Window grid: NR = (R_N_P−K)/S+1 rows × NC = (C_N_P−K)/S+1 columns, using integer division. Remainder rows/columns are never covered. Defaults give 3×3 = 9 windows.
- FSM states: IDLE, SCAN, DONE.
- IDLE → SCAN on `start`:
  - Capture `N_P` into an internal matrix register.
  - Set row = col = 0.
  - Load `win` with window (0,0).
- SCAN:
  - `win_valid` = 1.
  - On `win_valid && win_ready`:
    - If col+S ≤ C_N_P−K: col += S.
    - Else: col = 0, row += S.
    - Reload `win` from the captured matrix at the new (row,col).
  - When the accepted window is the last one (row = (NR−1)·S, col = (NC−1)·S), go to DONE instead.
- DONE: `done` = 1 for exactly one cycle, then → IDLE.
- `win` element (i,j) = captured(row+i, col+j). Plain copy, no arithmetic.
- `start` in SCAN or DONE is ignored. `N_P` changes after capture have no effect on the current scan.
- Backpressure: while `win_valid && !win_ready`, `win`, `win_row` and `win_col` are held stable.
- `clr` (synchronous, priority over everything except `rst`): → IDLE, all outputs zero, scan abandoned, no `done` pulse.
- `rst` low (asynchronous, any time): state IDLE, matrix register, `win`, `win_row`, `win_col`, `win_valid`, `busy` and `done` all 0.

## Timing
- Reset value of every output: 0.
- Let `start` be sampled at edge t:
  - `busy` and `win_valid` go high after edge t, with window (0,0).
- With `win_ready` held high:
  - One window per cycle.
  - The last window is accepted at edge t+NR·NC.
  - `done` is high in the following cycle.
  - `busy` falls one cycle later.
- Total for defaults: 9 window cycles + 1 DONE cycle.
- `win_valid` never drops between windows within a scan.
- `win_valid` is low in DONE and IDLE.
- The earliest next `start` is accepted in the cycle after DONE.

## Test plan
- **Full scan, defaults, `win_ready`=1:** load N_P(r,c)=10r+c and pulse `start`.
  - Expect 9 consecutive windows with (row,col) = (0,0),(0,1),(0,2),(1,0)…(2,2).
  - Window (1,2) = {12,13,14,22,23,24,32,33,34}.
  - `done` pulses one cycle after the 9th window; `busy` falls the cycle after that.
- **Backpressure:** hold `win_ready`=0 for 4 cycles on window (0,1).
  - `win`, `win_row` and `win_col` stay stable; `win_valid` stays 1.
  - The scan resumes correctly, with 9 total windows and none duplicated or skipped.
- **Stride 2 instance (S=2, 5×5, K=3):**
  - Expect exactly 4 windows at (0,0),(0,2),(2,0),(2,2).
  - Window (2,2) = {22,23,24,32,33,34,42,43,44}.
- **`start` and `N_P` change mid-scan:** re-pulse `start` and drive `N_P` to all 0xFFFFFFFF during window 3.
  - Remaining windows still come from the original matrix.
  - Only one `done` pulse.
- **`clr` mid-scan:** assert for one cycle at window 5.
  - Next cycle: `win_valid`=0, `busy`=0, `win`=0, no `done` pulse.
  - A fresh `start` then yields the full 9 windows.
- **Async reset:** drop `rst` between clock edges during window 4.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, the block idles until `start`.
